// File: rtl/editor_hora_fecha_pkg.sv
// Shared constants for the time/date keyboard editor: PS/2 scancodes,
// field indices, field ranges and the editor state encoding.
package editor_hora_fecha_pkg;

  // PS/2 set-2 make codes used by the editor
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Field indices as presented on Campo
  localparam logic [2:0] CAMPO_SEG  = 3'd0;
  localparam logic [2:0] CAMPO_MIN  = 3'd1;
  localparam logic [2:0] CAMPO_HORA = 3'd2;
  localparam logic [2:0] CAMPO_DIA  = 3'd3;
  localparam logic [2:0] CAMPO_MES  = 3'd4;
  localparam logic [2:0] CAMPO_YEAR = 3'd5;

  // Field ranges; the year maximum is a parameter of the top module
  localparam logic [6:0] SEG_MIN  = 7'd0;
  localparam logic [6:0] SEG_MAX  = 7'd59;
  localparam logic [6:0] MIN_MIN  = 7'd0;
  localparam logic [6:0] MIN_MAX  = 7'd59;
  localparam logic [6:0] HORA_MIN = 7'd0;
  localparam logic [6:0] HORA_MAX = 7'd23;
  localparam logic [6:0] DIA_MIN  = 7'd1;
  localparam logic [6:0] DIA_MAX  = 7'd31;
  localparam logic [6:0] MES_MIN  = 7'd1;
  localparam logic [6:0] MES_MAX  = 7'd12;
  localparam logic [6:0] YEAR_MIN = 7'd0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EDIT = 1'b1
  } estado_t;

endpackage

// File: rtl/editor_hora_fecha_ajuste.sv
// Cyclic increment/decrement of one field value. Values already outside
// [min, max] are snapped to min when going up and to max when going down.
module ajuste_ciclico (
  input  logic [6:0] valor_i,
  input  logic [6:0] min_i,
  input  logic [6:0] max_i,
  input  logic       subir_i,
  output logic [6:0] resultado_o
);

  // Step the value one unit in the requested direction with wrap/snap
  always_comb begin
    resultado_o = valor_i;
    if (subir_i) begin
      if ((valor_i < min_i) || (valor_i >= max_i)) begin
        resultado_o = min_i;
      end else begin
        resultado_o = valor_i + 7'd1;
      end
    end else begin
      if ((valor_i <= min_i) || (valor_i > max_i)) begin
        resultado_o = max_i;
      end else begin
        resultado_o = valor_i - 7'd1;
      end
    end
  end

endmodule

// File: rtl/editor_hora_fecha.sv
// Keyboard-driven time/date editor. Enter captures the live counters,
// arrows move between and adjust the six fields, Enter commits with a
// one-cycle Escribir strobe, Esc or an inactivity timeout abandons the edit.
module editor_hora_fecha
  import editor_hora_fecha_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CICLOS = 32'd500_000_000,
  parameter logic [6:0]  ANIO_MAX       = 7'd99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Dato_Tecla,
  input  logic       Tecla_Valida,
  input  logic [5:0] Cuenta_Segundos,
  input  logic [5:0] Cuenta_Minutos,
  input  logic [4:0] Cuenta_Horas,
  input  logic [4:0] Cuenta_Dia,
  input  logic [3:0] Cuenta_Mes,
  input  logic [6:0] Cuenta_Year,
  output logic [5:0] Set_Segundos,
  output logic [5:0] Set_Minutos,
  output logic [4:0] Set_Horas,
  output logic [4:0] Set_Dia,
  output logic [3:0] Set_Mes,
  output logic [6:0] Set_Year,
  output logic       Escribir,
  output logic       Modo_Edicion,
  output logic [2:0] Campo
);

  estado_t     estado_q, estado_d;
  logic [2:0]  campo_q, campo_d;
  logic [5:0]  seg_q, seg_d, min_q, min_d;
  logic [4:0]  hora_q, hora_d, dia_q, dia_d;
  logic [3:0]  mes_q, mes_d;
  logic [6:0]  year_q, year_d;
  logic        escribir_q, escribir_d;
  logic        break_q, break_d;
  logic [31:0] espera_q, espera_d;
  logic        tecla_ok, vencido;
  logic [6:0]  valor_sel, min_sel, max_sel, ajustado;

  // A key acts only when it is valid, not a prefix byte and not a release
  assign tecla_ok = Tecla_Valida && !break_q &&
                    (Dato_Tecla != SC_BREAK) && (Dato_Tecla != SC_EXT);

  // Inactivity expires on the idle cycle that would make the count reach the limit
  assign vencido = (TIMEOUT_CICLOS != 32'd0) && (estado_q == ST_EDIT) &&
                   !Tecla_Valida && (espera_q == TIMEOUT_CICLOS - 32'd1);

  // Route the selected field and its range to the shared adjuster
  always_comb begin
    valor_sel = year_q;
    min_sel   = YEAR_MIN;
    max_sel   = ANIO_MAX;
    case (campo_q)
      CAMPO_SEG:  begin valor_sel = {1'b0, seg_q};   min_sel = SEG_MIN;  max_sel = SEG_MAX;  end
      CAMPO_MIN:  begin valor_sel = {1'b0, min_q};   min_sel = MIN_MIN;  max_sel = MIN_MAX;  end
      CAMPO_HORA: begin valor_sel = {2'b00, hora_q}; min_sel = HORA_MIN; max_sel = HORA_MAX; end
      CAMPO_DIA:  begin valor_sel = {2'b00, dia_q};  min_sel = DIA_MIN;  max_sel = DIA_MAX;  end
      CAMPO_MES:  begin valor_sel = {3'b000, mes_q}; min_sel = MES_MIN;  max_sel = MES_MAX;  end
      default:    ;
    endcase
  end

  ajuste_ciclico u_ajuste (
    .valor_i     (valor_sel),
    .min_i       (min_sel),
    .max_i       (max_sel),
    .subir_i     (Dato_Tecla == SC_UP),
    .resultado_o (ajustado)
  );

  // Track the release prefix and the cycles elapsed since the last byte
  always_comb begin
    break_d = break_q;
    if (Tecla_Valida && (Dato_Tecla != SC_EXT)) begin
      if (break_q) begin
        break_d = 1'b0;
      end else if (Dato_Tecla == SC_BREAK) begin
        break_d = 1'b1;
      end
    end
    if (Tecla_Valida || (estado_q != ST_EDIT) || vencido) begin
      espera_d = 32'd0;
    end else begin
      espera_d = espera_q + 32'd1;
    end
  end

  // Editor state transitions
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ST_IDLE: if (tecla_ok && (Dato_Tecla == SC_ENTER)) estado_d = ST_EDIT;
      ST_EDIT: begin
        if (tecla_ok && ((Dato_Tecla == SC_ENTER) || (Dato_Tecla == SC_ESC))) begin
          estado_d = ST_IDLE;
        end else if (vencido) begin
          estado_d = ST_IDLE;
        end
      end
      default: estado_d = ST_IDLE;
    endcase
  end

  // Field values, selected field and commit strobe for the next cycle
  always_comb begin
    campo_d    = campo_q;
    seg_d      = seg_q;
    min_d      = min_q;
    hora_d     = hora_q;
    dia_d      = dia_q;
    mes_d      = mes_q;
    year_d     = year_q;
    escribir_d = 1'b0;
    if (tecla_ok && (estado_q == ST_IDLE) && (Dato_Tecla == SC_ENTER)) begin
      campo_d = CAMPO_SEG;
      seg_d   = Cuenta_Segundos;
      min_d   = Cuenta_Minutos;
      hora_d  = Cuenta_Horas;
      dia_d   = Cuenta_Dia;
      mes_d   = Cuenta_Mes;
      year_d  = Cuenta_Year;
    end else if (tecla_ok && (estado_q == ST_EDIT)) begin
      case (Dato_Tecla)
        SC_RIGHT: campo_d = (campo_q == CAMPO_YEAR) ? CAMPO_SEG : campo_q + 3'd1;
        SC_LEFT:  campo_d = (campo_q == CAMPO_SEG) ? CAMPO_YEAR : campo_q - 3'd1;
        SC_UP, SC_DOWN: begin
          case (campo_q)
            CAMPO_SEG:  seg_d  = ajustado[5:0];
            CAMPO_MIN:  min_d  = ajustado[5:0];
            CAMPO_HORA: hora_d = ajustado[4:0];
            CAMPO_DIA:  dia_d  = ajustado[4:0];
            CAMPO_MES:  mes_d  = ajustado[3:0];
            default:    year_d = ajustado;
          endcase
        end
        SC_ENTER: escribir_d = 1'b1;
        default:  ;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= ST_IDLE;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Datapath registers; day and month reset to their minimum of 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      campo_q    <= CAMPO_SEG;
      seg_q      <= 6'd0;
      min_q      <= 6'd0;
      hora_q     <= 5'd0;
      dia_q      <= 5'd1;
      mes_q      <= 4'd1;
      year_q     <= 7'd0;
      escribir_q <= 1'b0;
      break_q    <= 1'b0;
      espera_q   <= 32'd0;
    end else begin
      campo_q    <= campo_d;
      seg_q      <= seg_d;
      min_q      <= min_d;
      hora_q     <= hora_d;
      dia_q      <= dia_d;
      mes_q      <= mes_d;
      year_q     <= year_d;
      escribir_q <= escribir_d;
      break_q    <= break_d;
      espera_q   <= espera_d;
    end
  end

  assign Set_Segundos = seg_q;
  assign Set_Minutos  = min_q;
  assign Set_Horas    = hora_q;
  assign Set_Dia      = dia_q;
  assign Set_Mes      = mes_q;
  assign Set_Year     = year_q;
  assign Escribir     = escribir_q;
  assign Modo_Edicion = (estado_q == ST_EDIT);
  assign Campo        = campo_q;

endmodule
